// File: rtl/dft_dump_sequencer.sv
// Sequences N functional DUT ops followed by one scan dump on the DUFT core handshakes,
// and buffers the scan words in a show-ahead capture FIFO for the register-side reader.
module dft_dump_sequencer #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic                              i_clear,
    input  logic [15:0]                       i_n_ops,
    input  logic [DATA_W-1:0]                 i_op_data,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_error,
    output logic                              o_overflow,
    output logic [DATA_W-1:0]                 o_last_result,
    output logic [DATA_W-1:0]                 o_dut_input_vec,
    input  logic [DATA_W-1:0]                 i_dut_output_vec,
    output logic                              o_dut_val_op,
    output logic                              o_dut_commit_ack,
    input  logic                              i_dut_op_ack,
    input  logic                              i_dut_op_commit,
    output logic                              o_dut_sen,
    output logic                              o_dft_val_op,
    output logic                              o_dft_commit_ack,
    input  logic                              i_dft_op_ack,
    input  logic                              i_dft_op_commit,
    input  logic [DATA_W-1:0]                 i_dft_output_data,
    input  logic                              i_dft_output_strobe,
    input  logic                              i_cap_rd_en,
    output logic [DATA_W-1:0]                 o_cap_data,
    output logic                              o_cap_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_cap_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DUT_REQ,
        S_DUT_WAIT,
        S_DUT_ACK,
        S_SCAN_REQ,
        S_SCAN_WAIT,
        S_SCAN_ACK,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_n_ops;
    logic [15:0]        r_op_cnt;
    logic [7:0]         r_wd;
    logic               w_wd_run;
    logic               w_wd_expired;
    logic               w_start_acc;
    logic               r_overflow;
    logic [DATA_W-1:0]  r_last_result;
    logic [DATA_W-1:0]  r_dut_input_vec;

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_full;
    logic               w_empty;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_push_drop;

    assign w_start_acc  = (r_state == S_IDLE) && i_start;
    // The cycle in which the counter would reach TIMEOUT is the last one spent waiting.
    assign w_wd_expired = (r_wd == 8'(TIMEOUT - 1));

    always_comb begin
        w_next           = r_state;
        w_wd_run         = 1'b0;
        o_busy           = 1'b1;
        o_done           = 1'b0;
        o_error          = 1'b0;
        o_dut_val_op     = 1'b0;
        o_dut_commit_ack = 1'b0;
        o_dut_sen        = 1'b0;
        o_dft_val_op     = 1'b0;
        o_dft_commit_ack = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start)
                    w_next = (i_n_ops != 16'd0) ? S_DUT_REQ : S_SCAN_REQ;
            end
            S_DUT_REQ: begin
                o_dut_val_op = 1'b1;
                w_wd_run     = 1'b1;
                if (i_dut_op_ack)      w_next = S_DUT_WAIT;
                else if (w_wd_expired) w_next = S_ERR;
            end
            S_DUT_WAIT: begin
                w_wd_run = 1'b1;
                if (i_dut_op_commit)   w_next = S_DUT_ACK;
                else if (w_wd_expired) w_next = S_ERR;
            end
            S_DUT_ACK: begin
                o_dut_commit_ack = 1'b1;
                w_next = (r_op_cnt + 16'd1 == r_n_ops) ? S_SCAN_REQ : S_DUT_REQ;
            end
            S_SCAN_REQ: begin
                o_dft_val_op = 1'b1;
                o_dut_sen    = 1'b1;
                w_wd_run     = 1'b1;
                if (i_dft_op_ack)      w_next = S_SCAN_WAIT;
                else if (w_wd_expired) w_next = S_ERR;
            end
            S_SCAN_WAIT: begin
                o_dut_sen = 1'b1;
                w_wd_run  = 1'b1;
                if (i_dft_op_commit)   w_next = S_SCAN_ACK;
                else if (w_wd_expired) w_next = S_ERR;
            end
            S_SCAN_ACK: begin
                o_dft_commit_ack = 1'b1;
                o_dut_sen        = 1'b1;
                w_next           = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                o_busy  = 1'b0;
                o_error = 1'b1;
                if (i_clear) w_next = S_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_n_ops         <= '0;
            r_op_cnt        <= '0;
            r_wd            <= '0;
            r_overflow      <= 1'b0;
            r_last_result   <= '0;
            r_dut_input_vec <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wd <= '0;
            else if (w_wd_run)
                r_wd <= r_wd + 8'd1;
            if (w_start_acc) begin
                r_n_ops         <= i_n_ops;
                r_dut_input_vec <= i_op_data;
                r_op_cnt        <= '0;
            end else if (r_state == S_DUT_ACK) begin
                r_op_cnt <= r_op_cnt + 16'd1;
            end
            if (r_state == S_DUT_WAIT && i_dut_op_commit)
                r_last_result <= i_dut_output_vec;
            if (w_start_acc)
                r_overflow <= 1'b0;
            else if (w_push_drop)
                r_overflow <= 1'b1;
        end
    end

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push alongside it.
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push_req  = (r_state == S_SCAN_WAIT) && i_dft_output_strobe;
    assign w_pop       = i_cap_rd_en && !w_empty;
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_push_drop = w_push_req && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_dft_output_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_overflow      = r_overflow;
    assign o_last_result   = r_last_result;
    assign o_dut_input_vec = r_dut_input_vec;
    assign o_cap_data      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_cap_empty     = w_empty;
    assign o_cap_count     = r_count;

endmodule

// File: tb/tb_dft_dump_sequencer.sv
// Bench for dft_dump_sequencer: the bench plays the DUFT core, predicts every output from the
// handshake timing rules plus a queue model of the capture FIFO, and compares each cycle.
module tb_dft_dump_sequencer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int TMO    = 255;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clear;
    logic [15:0] n_ops;
    logic [31:0] op_data, dut_output_vec, dft_output_data;
    logic        dut_op_ack, dut_op_commit, dft_op_ack, dft_op_commit, strobe, rd_en;

    logic        o_busy, o_done, o_error, o_overflow;
    logic [31:0] o_last_result, o_dut_input_vec, o_cap_data;
    logic        o_dut_val_op, o_dut_commit_ack, o_dut_sen, o_dft_val_op, o_dft_commit_ack;
    logic        o_cap_empty;
    logic [3:0]  o_cap_count;

    dft_dump_sequencer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clear),
        .i_n_ops(n_ops), .i_op_data(op_data),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_overflow(o_overflow),
        .o_last_result(o_last_result), .o_dut_input_vec(o_dut_input_vec),
        .i_dut_output_vec(dut_output_vec),
        .o_dut_val_op(o_dut_val_op), .o_dut_commit_ack(o_dut_commit_ack),
        .i_dut_op_ack(dut_op_ack), .i_dut_op_commit(dut_op_commit),
        .o_dut_sen(o_dut_sen),
        .o_dft_val_op(o_dft_val_op), .o_dft_commit_ack(o_dft_commit_ack),
        .i_dft_op_ack(dft_op_ack), .i_dft_op_commit(dft_op_commit),
        .i_dft_output_data(dft_output_data), .i_dft_output_strobe(strobe),
        .i_cap_rd_en(rd_en), .o_cap_data(o_cap_data), .o_cap_empty(o_cap_empty),
        .o_cap_count(o_cap_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic [31:0] fq[$];
    logic [31:0] e_last = '0, e_inp = '0;
    bit          e_ovf = 0;
    bit          e_busy = 0, e_vd = 0, e_cd = 0, e_sen = 0, e_vf = 0, e_cf = 0, e_dn = 0, e_er = 0;
    bit          chk_en = 0;

    // stimulus knobs
    bit          rnd = 0;
    int          ack_dly = 0;
    int          strobe_pct = 40;
    int          rd_pct = 30;
    bit          commit_with_last = 0;
    bit          rd_hold = 0;
    logic [31:0] res_q[$];
    logic [31:0] wq[$];

    int n_cack = 0, n_dvo = 0, n_done = 0;

    logic [109:0] act_v, exp_v;
    logic [31:0]  exp_head;

    always @(negedge clk) begin
        if (o_dut_commit_ack) n_cack++;
        if (o_dut_val_op)     n_dvo++;
        if (o_done)           n_done++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_head = (fq.size() == 0) ? 32'h0 : fq[0];
            act_v = {o_busy, o_done, o_error, o_overflow, o_dut_val_op, o_dut_commit_ack, o_dut_sen,
                     o_dft_val_op, o_dft_commit_ack, o_cap_empty, o_cap_count,
                     o_last_result, o_dut_input_vec, o_cap_data};
            exp_v = {e_busy, e_dn, e_er, e_ovf, e_vd, e_cd, e_sen, e_vf, e_cf,
                     (fq.size() == 0), 4'(fq.size()), e_last, e_inp, exp_head};
            n_checks++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, act_v, exp_v);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, act, expv);
    endtask

    task automatic ex(input bit b, vd, cd, sen, vf, cf, dn, er);
        e_busy = b; e_vd = vd; e_cd = cd; e_sen = sen; e_vf = vf; e_cf = cf; e_dn = dn; e_er = er;
    endtask

    // Compare happens at the negedge; the FIFO model then absorbs this cycle's push/pop.
    task automatic step(input bit scan_wait);
        @(negedge clk); #1;
        if (rst_n) begin
            if (rd_en && fq.size() > 0) void'(fq.pop_front());
            if (scan_wait && strobe) begin
                if (fq.size() < DEPTH) fq.push_back(dft_output_data);
                else e_ovf = 1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic noise();
        if (rnd) begin
            start = 1'($urandom_range(0, 1));  clear = 1'($urandom_range(0, 1));
            n_ops = 16'($urandom);             op_data = $urandom;
            dut_op_ack = 1'($urandom_range(0, 1));    dut_op_commit = 1'($urandom_range(0, 1));
            dft_op_ack = 1'($urandom_range(0, 1));    dft_op_commit = 1'($urandom_range(0, 1));
            dut_output_vec = $urandom;         dft_output_data = $urandom;
            strobe = ($urandom_range(0, 99) < strobe_pct);
            rd_en  = ($urandom_range(0, 99) < rd_pct);
        end else begin
            start = 0; clear = 0; n_ops = '0; op_data = '0;
            dut_op_ack = 0; dut_op_commit = 0; dft_op_ack = 0; dft_op_commit = 0;
            dut_output_vec = '0; dft_output_data = '0; strobe = 0; rd_en = 0;
        end
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) begin
            noise(); start = 0; ex(0, 0, 0, 0, 0, 0, 0, 0); step(0);
        end
    endtask

    task automatic drain();
        for (int j = 0; j <= DEPTH && fq.size() > 0; j++) begin
            noise(); start = 0; rd_en = 1; ex(0, 0, 0, 0, 0, 0, 0, 0); step(0);
        end
        rd_en = 0;
    endtask

    // Starts from IDLE and ends after the DONE cycle.
    task automatic run_seq(input int n, input logic [31:0] data);
        int d, k, cyc;
        logic [31:0] v;
        noise(); start = 1; n_ops = 16'(n); op_data = data;
        ex(0, 0, 0, 0, 0, 0, 0, 0); step(0);
        e_ovf = 0; e_inp = data;
        for (int op = 0; op < n; op++) begin
            d = rnd ? int'($urandom_range(0, 4)) : ack_dly;
            for (int j = 0; j <= d; j++) begin
                noise(); dut_op_ack = (j == d); ex(1, 1, 0, 0, 0, 0, 0, 0); step(0);
            end
            d = rnd ? int'($urandom_range(0, 4)) : 1;
            v = rnd ? $urandom : ((res_q.size() > 0) ? res_q.pop_front() : 32'h0);
            for (int j = 0; j <= d; j++) begin
                noise(); dut_op_commit = (j == d);
                if (j == d) dut_output_vec = v;
                ex(1, 0, 0, 0, 0, 0, 0, 0); step(0);
            end
            e_last = v;
            noise(); ex(1, 0, 1, 0, 0, 0, 0, 0); step(0);
        end
        d = rnd ? int'($urandom_range(0, 4)) : ack_dly;
        for (int j = 0; j <= d; j++) begin
            noise(); dft_op_ack = (j == d); ex(1, 0, 0, 1, 1, 0, 0, 0); step(0);
        end
        if (rnd) begin
            d = $urandom_range(0, 6);
            for (int j = 0; j <= d; j++) begin
                noise(); dft_op_commit = (j == d); ex(1, 0, 0, 1, 0, 0, 0, 0); step(1);
            end
        end else begin
            k = wq.size();
            cyc = (commit_with_last && k > 0) ? k : k + 1;
            for (int j = 0; j < cyc; j++) begin
                noise();
                if (j < k) begin
                    strobe = 1; dft_output_data = wq[j];
                    if (rd_hold) rd_en = 1;
                end
                dft_op_commit = (j == cyc - 1);
                ex(1, 0, 0, 1, 0, 0, 0, 0); step(1);
            end
            wq.delete();
        end
        noise(); ex(1, 0, 0, 1, 0, 1, 0, 0); step(0);
        noise(); ex(1, 0, 0, 0, 0, 0, 1, 0); step(0);
    endtask

    task automatic timeout_seq();
        noise(); start = 1; n_ops = 16'd1; op_data = 32'h0000_7A7A;
        ex(0, 0, 0, 0, 0, 0, 0, 0); step(0);
        e_ovf = 0; e_inp = 32'h0000_7A7A;
        for (int j = 0; j < TMO; j++) begin
            noise(); dut_op_ack = 0; ex(1, 1, 0, 0, 0, 0, 0, 0); step(0);
        end
        for (int j = 0; j < 4; j++) begin
            noise(); start = 1; clear = 0; ex(0, 0, 0, 0, 0, 0, 0, 1);
            if (j == 2) begin
                chk("err_error", 32'(o_error), 32'd1);
                chk("err_dut_val_op", 32'(o_dut_val_op), 32'd0);
            end
            step(0);
        end
        noise(); clear = 1; ex(0, 0, 0, 0, 0, 0, 0, 1); step(0);
        idle(2);
    endtask

    initial begin
        rst_n = 0;
        rnd = 0; noise();
        chk_en = 1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_cap_empty", 32'(o_cap_empty), 32'd1);
        chk("rst_cap_count", 32'(o_cap_count), 32'd0);
        rst_n = 1;
        idle(2);

        // dump only
        ack_dly = 2; commit_with_last = 0; rd_hold = 0;
        wq = '{32'hA5A5_0001, 32'hA5A5_0002};
        n_dvo = 0; n_done = 0;
        run_seq(0, 32'h0000_0042);
        chk("dump_dut_val_op_cycles", 32'(n_dvo), 32'd0);
        chk("dump_done_pulses", 32'(n_done), 32'd1);
        chk("dump_cap_count", 32'(o_cap_count), 32'd2);
        chk("dump_head0", o_cap_data, 32'hA5A5_0001);
        noise(); rd_en = 1; ex(0, 0, 0, 0, 0, 0, 0, 0); step(0);
        chk("dump_head1", o_cap_data, 32'hA5A5_0002);
        drain();

        // functional ops then dump
        ack_dly = 0;
        res_q = '{32'h10, 32'h20, 32'h30};
        n_cack = 0;
        run_seq(3, 32'h0000_1234);
        chk("func_commit_acks", 32'(n_cack), 32'd3);
        chk("func_last_result", o_last_result, 32'h30);
        chk("func_input_vec", o_dut_input_vec, 32'h1234);
        idle(1);

        // strobe together with commit
        commit_with_last = 1;
        wq = '{32'hDEAD_BEEF};
        run_seq(0, 32'h0);
        chk("samecyc_count", 32'(o_cap_count), 32'd1);
        chk("samecyc_head", o_cap_data, 32'hDEAD_BEEF);
        drain();
        commit_with_last = 0;

        // overflow, then a push against a full FIFO with a simultaneous pop
        for (int i = 0; i < 10; i++) wq.push_back(32'hC000_0000 + 32'(i));
        run_seq(0, 32'h0);
        chk("ovf_count", 32'(o_cap_count), 32'd8);
        chk("ovf_flag", 32'(o_overflow), 32'd1);
        chk("ovf_head", o_cap_data, 32'hC000_0000);
        rd_hold = 1;
        wq = '{32'hC0DE_0001};
        run_seq(0, 32'h0);
        rd_hold = 0;
        chk("fullpop_count", 32'(o_cap_count), 32'd8);
        chk("fullpop_flag", 32'(o_overflow), 32'd0);
        chk("fullpop_head", o_cap_data, 32'hC000_0001);
        drain();

        // watchdog
        timeout_seq();

        // reset in the middle of a dump
        noise(); start = 1; n_ops = '0; op_data = 32'h0000_ABCD;
        ex(0, 0, 0, 0, 0, 0, 0, 0); step(0);
        e_ovf = 0; e_inp = 32'h0000_ABCD;
        noise(); dft_op_ack = 1; ex(1, 0, 0, 1, 1, 0, 0, 0); step(0);
        for (int j = 0; j < 2; j++) begin
            noise(); strobe = 1; dft_output_data = 32'hF00D_0000 + 32'(j);
            ex(1, 0, 0, 1, 0, 0, 0, 0); step(1);
        end
        rst_n = 0; #1;
        chk("rstmid_busy", 32'(o_busy), 32'd0);
        chk("rstmid_sen", 32'(o_dut_sen), 32'd0);
        chk("rstmid_empty", 32'(o_cap_empty), 32'd1);
        chk("rstmid_input_vec", o_dut_input_vec, 32'd0);
        fq.delete(); e_ovf = 0; e_last = '0; e_inp = '0;
        ex(0, 0, 0, 0, 0, 0, 0, 0);
        step(0); step(0);
        rst_n = 1;
        idle(1);
        res_q = '{32'h55};
        wq = '{32'h77};
        run_seq(1, 32'h99);
        chk("post_rst_last", o_last_result, 32'h55);
        chk("post_rst_head", o_cap_data, 32'h77);
        drain();

        // randomized sequences with stray handshakes, strobes and reads
        rnd = 1;
        for (int s = 0; s < 40; s++) begin
            run_seq(int'($urandom_range(0, 4)), $urandom);
            idle(int'($urandom_range(0, 3)));
        end
        timeout_seq();
        for (int s = 0; s < 5; s++) begin
            run_seq(int'($urandom_range(0, 3)), $urandom);
            idle(1);
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
